// File: rtl/iprefetch_queue.sv
// Instruction prefetch queue: fetches aligned 4-halfword blocks into a halfword
// ring and presents a 4-halfword window at the head PC to the fetcher.
module iprefetch_queue #(
   parameter int ADDR_W   = 25,
   parameter int DEPTH_HW = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic              mem_rvalid_i,
   input  logic [63:0]       mem_rdata_i,
   output logic [63:0]       window_o,
   output logic [ADDR_W-1:0] window_pc_o,
   output logic [2:0]        avail_o,
   input  logic [2:0]        consume_i
);

   localparam int PTR_W = $clog2(DEPTH_HW);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FOUR  = CNT_W'(4);
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(DEPTH_HW);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            state, state_nxt;
   logic [PTR_W-1:0]  head, tail;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] head_pc, fetch_pc;
   logic [1:0]        skip;
   logic              drop;
   logic [15:0]       mem [DEPTH_HW];

   logic [CNT_W-1:0]  free;
   logic [2:0]        avail, cons, n_wr;
   logic              wr_en, ack_take;
   logic [63:0]       rd_shift;

   assign free     = DEPTH - count;
   assign avail    = (count >= FOUR) ? 3'd4 : count[2:0];
   assign cons     = (consume_i > avail) ? avail : consume_i;
   assign ack_take = (state == REQ) && mem_ack_i;
   // A response is written only if it belongs to the current fetch stream.
   assign wr_en    = (state == WAIT) && mem_rvalid_i && !drop && !redirect_i;
   assign n_wr     = 3'd4 - {1'b0, skip};
   assign rd_shift = mem_rdata_i >> {skip, 4'b0000};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!redirect_i && free >= FOUR) state_nxt = REQ;
         REQ:     if (mem_ack_i)                   state_nxt = WAIT;
                  else if (redirect_i)             state_nxt = IDLE;
         WAIT:    if (mem_rvalid_i)                state_nxt = IDLE;
         default:                                  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req_o  = (state == REQ);
      mem_addr_o = '0;
      if (state == REQ) mem_addr_o = {fetch_pc[ADDR_W-1:2], 2'b00};
   end

   // An outstanding request that survives a redirect must have its response dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         drop <= 1'b0;
      else if (redirect_i && ((state == WAIT && !mem_rvalid_i) || ack_take))
         drop <= 1'b1;
      else if (state == WAIT && mem_rvalid_i)
         drop <= 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         head_pc  <= '0;
         fetch_pc <= '0;
         skip     <= '0;
      end else if (redirect_i) begin
         count    <= '0;
         tail     <= head;
         head_pc  <= redirect_pc_i;
         fetch_pc <= redirect_pc_i;
         skip     <= redirect_pc_i[1:0];
      end else begin
         count   <= count + (wr_en ? CNT_W'(n_wr) : '0) - CNT_W'(cons);
         head    <= head + PTR_W'(cons);
         head_pc <= head_pc + ADDR_W'(cons);
         if (wr_en) begin
            tail <= tail + PTR_W'(n_wr);
            skip <= '0;
         end
         if (ack_take) fetch_pc <= {fetch_pc[ADDR_W-1:2] + 1'b1, 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < 4; j++)
         if (wr_en && 3'(j) < n_wr)
            mem[tail + PTR_W'(j)] <= rd_shift[16*j +: 16];
   end

   always_comb begin
      window_o = '0;
      for (int i = 0; i < 4; i++)
         if (3'(i) < avail) window_o[16*i +: 16] = mem[head + PTR_W'(i)];
   end

   assign avail_o     = avail;
   assign window_pc_o = head_pc;

endmodule

// File: tb/tb_iprefetch_queue.sv
// Directed bench for iprefetch_queue: a cycle table for the basic flows plus
// hand sequences for fill/backpressure, same-cycle write+consume, wrap and reset.
module tb_iprefetch_queue;
   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_i;
   logic [24:0] redirect_pc_i;
   logic        mem_req_o;
   logic [24:0] mem_addr_o;
   logic        mem_ack_i;
   logic        mem_rvalid_i;
   logic [63:0] mem_rdata_i;
   logic [63:0] window_o;
   logic [24:0] window_pc_o;
   logic [2:0]  avail_o;
   logic [2:0]  consume_i;

   int n_chk = 0;
   int n_fail = 0;

   iprefetch_queue #(.ADDR_W(25), .DEPTH_HW(16)) dut (
      .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .window_o(window_o),
      .window_pc_o(window_pc_o), .avail_o(avail_o), .consume_i(consume_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (reset && consume_i > avail_o) $error("illegal consume %0d with avail %0d", consume_i, avail_o);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        redir;
      logic [24:0] rpc;
      logic        ack;
      logic        rv;
      logic [63:0] rd;
      logic [2:0]  cons;
      logic        e_req;
      logic [24:0] e_addr;
      logic [2:0]  e_avail;
      logic [63:0] e_win;
      logic [24:0] e_pc;
   } vec_t;

   vec_t tv[19];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_win(input string nm, input logic [2:0] av, input logic [63:0] w, input logic [24:0] pc);
      chk({nm, " avail"}, 64'(avail_o), 64'(av));
      chk({nm, " window"}, window_o, w);
      chk({nm, " pc"}, 64'(window_pc_o), 64'(pc));
   endtask

   task automatic wait_req(input string nm, input logic [24:0] addr);
      int k;
      for (k = 0; k < 20 && !mem_req_o; k++) @(negedge clk);
      chk({nm, " req seen"}, 64'(mem_req_o), 64'd1);
      chk({nm, " addr"}, 64'(mem_addr_o), 64'(addr));
   endtask

   // Called at a negedge: accept the next request, return data one cycle later.
   task automatic serve(input string nm, input logic [24:0] addr, input logic [63:0] d, input logic [2:0] c);
      wait_req(nm, addr);
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = d; consume_i = c;
      @(negedge clk);
      mem_rvalid_i = 1'b0; consume_i = 3'd0;
   endtask

   task automatic redirect(input logic [24:0] pc);
      redirect_i = 1'b1; redirect_pc_i = pc;
      @(negedge clk);
      redirect_i = 1'b0;
   endtask

   task automatic consume(input logic [2:0] c);
      consume_i = c;
      @(negedge clk);
      consume_i = 3'd0;
   endtask

   initial begin
      logic seen;
      //          redir rpc        ack rv rd                      cons req addr       av win                      pc
      tv[0]  = '{0, 25'h0,     0, 0, 64'h0,                   0, 0, 25'h0,     0, 64'h0,                   25'h0};
      tv[1]  = '{0, 25'h0,     1, 0, 64'h0,                   0, 1, 25'h0,     0, 64'h0,                   25'h0};
      tv[2]  = '{0, 25'h0,     0, 0, 64'h0,                   0, 0, 25'h0,     0, 64'h0,                   25'h0};
      tv[3]  = '{0, 25'h0,     0, 1, 64'h4444_3333_2222_1111, 0, 0, 25'h0,     0, 64'h0,                   25'h0};
      tv[4]  = '{0, 25'h0,     0, 0, 64'h0,                   1, 0, 25'h0,     4, 64'h4444_3333_2222_1111, 25'h0};
      tv[5]  = '{0, 25'h0,     0, 0, 64'h0,                   0, 1, 25'h4,     3, 64'h0000_4444_3333_2222, 25'h1};
      tv[6]  = '{1, 25'h6,     0, 0, 64'h0,                   0, 1, 25'h4,     3, 64'h0000_4444_3333_2222, 25'h1};
      tv[7]  = '{0, 25'h0,     0, 0, 64'h0,                   0, 0, 25'h0,     0, 64'h0,                   25'h6};
      tv[8]  = '{0, 25'h0,     1, 0, 64'h0,                   0, 1, 25'h4,     0, 64'h0,                   25'h6};
      tv[9]  = '{0, 25'h0,     0, 1, 64'hDDDD_CCCC_BBBB_AAAA, 0, 0, 25'h0,     0, 64'h0,                   25'h6};
      tv[10] = '{0, 25'h0,     0, 0, 64'h0,                   0, 0, 25'h0,     2, 64'h0000_0000_DDDD_CCCC, 25'h6};
      tv[11] = '{0, 25'h0,     1, 0, 64'h0,                   0, 1, 25'h8,     2, 64'h0000_0000_DDDD_CCCC, 25'h6};
      tv[12] = '{1, 25'h100,   0, 0, 64'h0,                   0, 0, 25'h0,     2, 64'h0000_0000_DDDD_CCCC, 25'h6};
      tv[13] = '{0, 25'h0,     0, 1, 64'h1234_5678_9ABC_DEF0, 0, 0, 25'h0,     0, 64'h0,                   25'h100};
      tv[14] = '{0, 25'h0,     0, 0, 64'h0,                   0, 0, 25'h0,     0, 64'h0,                   25'h100};
      tv[15] = '{0, 25'h0,     1, 0, 64'h0,                   0, 1, 25'h100,   0, 64'h0,                   25'h100};
      tv[16] = '{0, 25'h0,     0, 1, 64'h8888_7777_6666_5555, 0, 0, 25'h0,     0, 64'h0,                   25'h100};
      tv[17] = '{0, 25'h0,     0, 0, 64'h0,                   4, 0, 25'h0,     4, 64'h8888_7777_6666_5555, 25'h100};
      tv[18] = '{0, 25'h0,     0, 0, 64'h0,                   0, 1, 25'h104,   0, 64'h0,                   25'h104};

      reset = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; mem_ack_i = 1'b0;
      mem_rvalid_i = 1'b0; mem_rdata_i = '0; consume_i = 3'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset req", 64'(mem_req_o), 64'd0);
      chk("reset addr", 64'(mem_addr_o), 64'd0);
      chk_win("reset", 3'd0, 64'h0, 25'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 19; i++) begin
         redirect_i = tv[i].redir; redirect_pc_i = tv[i].rpc; mem_ack_i = tv[i].ack;
         mem_rvalid_i = tv[i].rv; mem_rdata_i = tv[i].rd; consume_i = tv[i].cons;
         #1;
         chk($sformatf("v%0d req", i), 64'(mem_req_o), 64'(tv[i].e_req));
         chk($sformatf("v%0d addr", i), 64'(mem_addr_o), 64'(tv[i].e_addr));
         chk_win($sformatf("v%0d", i), tv[i].e_avail, tv[i].e_win, tv[i].e_pc);
         @(negedge clk);
      end
      redirect_i = 1'b0; mem_ack_i = 1'b0; mem_rvalid_i = 1'b0; consume_i = 3'd0;

      // Fill to capacity with no consumption: requests must stop.
      redirect(25'h200);
      serve("fill0", 25'h200, 64'h2003_2002_2001_2000, 3'd0);
      serve("fill1", 25'h204, 64'h2103_2102_2101_2100, 3'd0);
      serve("fill2", 25'h208, 64'h2203_2202_2201_2200, 3'd0);
      serve("fill3", 25'h20C, 64'h2303_2302_2301_2300, 3'd0);
      chk_win("full", 3'd4, 64'h2003_2002_2001_2000, 25'h200);
      seen = 1'b0;
      repeat (8) begin
         if (mem_req_o) seen = 1'b1;
         @(negedge clk);
      end
      chk("full no req", 64'(seen), 64'd0);
      consume(3'd4);
      wait_req("after drain", 25'h210);
      chk_win("after drain", 3'd4, 64'h2103_2102_2101_2100, 25'h204);

      // count=3, then write 4 and consume 2 in the same cycle.
      redirect(25'h301);
      serve("skip1", 25'h300, 64'h0A03_0A02_0A01_0A00, 3'd0);
      chk_win("skip1", 3'd3, 64'h0000_0A03_0A02_0A01, 25'h301);
      serve("wr+cons", 25'h304, 64'h0B03_0B02_0B01_0B00, 3'd2);
      chk_win("wr+cons", 3'd4, 64'h0B02_0B01_0B00_0A03, 25'h303);
      consume(3'd4);
      chk_win("count5 drain", 3'd1, 64'h0000_0000_0000_0B03, 25'h307);

      // Address space wrap.
      redirect(25'h1FFFFFE);
      serve("wrap0", 25'h1FFFFFC, 64'h3003_3002_3001_3000, 3'd0);
      chk_win("wrap0", 3'd2, 64'h0000_0000_3003_3002, 25'h1FFFFFE);
      serve("wrap1", 25'h0, 64'h3103_3102_3101_3100, 3'd0);
      chk_win("wrap1", 3'd4, 64'h3101_3100_3003_3002, 25'h1FFFFFE);
      consume(3'd2);
      chk_win("wrap pc", 3'd4, 64'h3103_3102_3101_3100, 25'h0);
      consume(3'd1);
      chk_win("wrap pc1", 3'd3, 64'h0000_3103_3102_3101, 25'h1);

      // Asynchronous reset while waiting for a response.
      wait_req("pre-reset", 25'h4);
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
      chk("pre-reset avail", 64'(avail_o), 64'd3);
      #2 reset = 1'b0;
      #1;
      chk("async req", 64'(mem_req_o), 64'd0);
      chk("async addr", 64'(mem_addr_o), 64'd0);
      chk_win("async", 3'd0, 64'h0, 25'h0);
      @(negedge clk);
      #2 reset = 1'b1;
      mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      chk("late rvalid avail", 64'(avail_o), 64'd0);
      serve("post-reset", 25'h0, 64'h4003_4002_4001_4000, 3'd0);
      chk_win("post-reset", 3'd4, 64'h4003_4002_4001_4000, 25'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/iprefetch_queue.md
Name: iprefetch_queue

Overview:
- Instruction prefetch queue directly upstream of the instruction fetcher.
- Issues 64-bit aligned block reads to instruction memory and buffers the returned halfwords in a ring.
- Presents a halfword-aligned 4-halfword window plus its PC; the fetcher consumes 1–4 halfwords per cycle (16/32/48/64-bit instructions).
- Handles branch redirects by flushing the queue and restarting fetch at the new PC.

Parameters:
ADDR_W, 25, halfword address width (PC unit = halfword)
DEPTH_HW, 16, queue capacity in halfwords; power of two, >= 8

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
redirect_i  in  1  flush queue and restart fetch at redirect_pc_i
redirect_pc_i  in  ADDR_W  new halfword PC
mem_req_o  out  1  block read request
mem_addr_o  out  ADDR_W  halfword address of request; bits [1:0] always 0
mem_ack_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  64  four halfwords; lowest address at [15:0]
window_o  out  64  next four queued halfwords; head at [15:0]
window_pc_o  out  ADDR_W  PC of halfword at window_o[15:0]
avail_o  out  3  valid halfwords in window, 0..4
consume_i  in  3  halfwords taken this cycle, 0..4; must be <= avail_o

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; count=0; head/tail=0; fetch_pc=0; skip=0; state IDLE; drop=0.
- Window: combinational from queue head. Halfwords at positions >= avail_o are driven 0. avail_o = min(count,4). window_pc_o = head_pc.
- FSM:
  - IDLE -> REQ when free space (DEPTH_HW-count) >= 4 and no redirect this cycle. Free space uses registered count; same-cycle consume is not credited.
  - REQ: mem_req_o=1, mem_addr_o={fetch_pc[ADDR_W-1:2],2'b00}. Hold until mem_ack_i=1, then -> WAIT; fetch_pc advances to next aligned block.
  - WAIT: on mem_rvalid_i, write halfwords skip..3 of mem_rdata_i at tail (4-skip halfwords); skip<=0; -> IDLE. Exactly one outstanding request.
- Redirect (redirect_i=1, highest priority):
  - count<=0; head=tail; head_pc<=redirect_pc_i; fetch_pc<=redirect_pc_i; skip<=redirect_pc_i[1:0]; consume_i ignored.
  - From IDLE/REQ -> IDLE; mem_req_o drops next cycle, so an un-acked request is withdrawn.
  - From WAIT (or mem_ack_i in the redirect cycle): drop<=1; next response is discarded, then -> IDLE.
  - rvalid in the redirect cycle is discarded.
- Queue update:
  - count_next = count + written - consume; head advances by consume; head_pc += consume, modulo 2^ADDR_W.
  - Simultaneous write and consume both apply.
  - Pointers wrap modulo DEPTH_HW.
  - Address wraps modulo 2^ADDR_W, so block 0x1FFFFFC is followed by 0x0000000.
- Latency: response data is visible on window_o the cycle after mem_rvalid_i.
- Safety: consume_i > avail_o is illegal; the bench asserts it never occurs. The design clamps consume to avail_o.
- Overflow is impossible by construction: a request is issued only with >= 4 free halfwords.

Test Plan:
1. Reset release, ack immediate, rvalid 2 cycles later with 0x4444_3333_2222_1111
   -> mem_addr_o=0, avail_o=4, window_o=0x4444_3333_2222_1111, window_pc_o=0.
   Then consume_i=1 -> window_o[15:0]=0x2222, window_pc_o=1.
2. Redirect to PC 0x0000006
   -> mem_addr_o=0x0000004; data 0xDDDD_CCCC_BBBB_AAAA yields avail_o=2, window_o=0x0000_0000_DDDD_CCCC, window_pc_o=6; next request addr 0x0000008.
3. Redirect to 0x100 while in WAIT
   -> following rvalid data discarded (avail_o stays 0); next mem_addr_o=0x100.
4. consume_i=0 with memory always ready
   -> count reaches 16, mem_req_o stays 0.
   consume_i=4 once -> mem_req_o=1 next cycle.
5. count=3, rvalid (4 halfwords) and consume_i=2 in same cycle
   -> count=5, window_pc_o advanced by 2.
6. reset asserted mid-WAIT between clock edges
   -> mem_req_o, avail_o, window_o, window_pc_o are 0 immediately.
   A late rvalid after release is ignored; the first request is to address 0.
